// File: rtl/systolic_ws_controller.sv
// systolic_ws_controller: weight-stationary systolic array sequencer with input skew and output deskew
module systolic_ws_controller #(
  parameter int ARRWIDTH  = 8,
  parameter int ARRHEIGHT = 8,
  parameter int WORDWIDTH = 8,
  parameter int SA_LAT    = 8,
  parameter int CNTWIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [CNTWIDTH-1:0]             num_vec,
  output logic                            busy,
  output logic                            done,
  input  logic                            w_valid,
  output logic                            w_ready,
  input  logic [WORDWIDTH*ARRWIDTH-1:0]   w_data,
  input  logic                            a_valid,
  output logic                            a_ready,
  input  logic [WORDWIDTH*ARRHEIGHT-1:0]  a_data,
  output logic                            sa_mode,
  output logic                            sa_w_shift,
  output logic [WORDWIDTH*ARRWIDTH-1:0]   sa_w_vec,
  output logic [WORDWIDTH*ARRHEIGHT-1:0]  sa_a_vec,
  input  logic [WORDWIDTH*4*ARRWIDTH-1:0] sa_ps_vec,
  output logic                            o_valid,
  output logic [WORDWIDTH*4*ARRWIDTH-1:0] o_data
);
  localparam int PW = WORDWIDTH * 4;
  localparam int TD = SA_LAT + ARRWIDTH;
  localparam int BW = $clog2(ARRHEIGHT + 1);
  localparam logic [BW-1:0] WLAST = BW'(ARRHEIGHT - 1);
  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;
  state_t state, nxt;
  logic [BW-1:0] wcnt;
  logic [CNTWIDTH-1:0] nv, acnt, outst;
  logic [TD-1:0] tag;
  logic w_beat, a_acc;
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
    w_ready = state == LOAD_W;
    a_ready = state == STREAM;
    sa_mode = state == STREAM || state == DRAIN;
    w_beat = w_valid && w_ready;
    a_acc = a_valid && a_ready;
    nxt = state;
    case (state)
      IDLE:    nxt = start ? LOAD_W : IDLE;
      LOAD_W:  nxt = !(w_beat && wcnt == WLAST) ? LOAD_W : nv == '0 ? DONE : STREAM;
      STREAM:  nxt = a_acc && acnt == nv - CNTWIDTH'(1) ? DRAIN : STREAM;
      DRAIN:   nxt = outst == '0 ? DONE : DRAIN;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= reset ? IDLE : nxt;
  always_ff @(posedge clk) begin
    if (reset) begin
      sa_w_shift <= 1'b0;
      sa_w_vec <= '0;
      wcnt <= '0;
      nv <= '0;
      acnt <= '0;
      outst <= '0;
      tag <= '0;
      o_valid <= 1'b0;
    end else begin
      sa_w_shift <= w_beat;
      if (w_beat) sa_w_vec <= w_data;
      wcnt <= state == IDLE ? '0 : wcnt + BW'(w_beat);
      if (start && state == IDLE) nv <= num_vec;
      acnt <= state == IDLE ? '0 : acnt + CNTWIDTH'(a_acc);
      outst <= outst + CNTWIDTH'(a_acc) - CNTWIDTH'(o_valid);
      tag <= {tag[TD-2:0], a_acc};
      o_valid <= tag[TD-1];
    end
  end
  for (genvar r = 0; r < ARRHEIGHT; r++) begin : g_skew
    logic [WORDWIDTH-1:0] sh [r+1];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int d = 0; d <= r; d++) sh[d] <= '0;
      end else begin
        sh[0] <= a_acc ? a_data[r*WORDWIDTH +: WORDWIDTH] : '0;
        for (int d = 1; d <= r; d++) sh[d] <= sh[d-1];
      end
    end
    assign sa_a_vec[r*WORDWIDTH +: WORDWIDTH] = sh[r];
  end
  for (genvar c = 0; c < ARRWIDTH; c++) begin : g_deskew
    localparam int D = ARRWIDTH - c;
    logic [PW-1:0] sh [D];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int d = 0; d < D; d++) sh[d] <= '0;
      end else begin
        sh[0] <= sa_ps_vec[c*PW +: PW];
        for (int d = 1; d < D; d++) sh[d] <= sh[d-1];
      end
    end
    assign o_data[c*PW +: PW] = sh[D-1];
  end
endmodule
